clk_div_prog: RTL

//  Runtime-programmable clock-enable/divider generator; parametrised successor of the fixed divide-by-10 divider.

---
 rtl/clk_div_prog.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: near-50% divided clock plus a one-cycle period tick.
// Divisor reloads are held pending and take effect only at a period boundary.
module clk_div_prog #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_clr,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_cur,
   output logic             div_pending
);

   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

   if (DEFAULT_DIV < 2 || DEFAULT_DIV >= (2 ** CNT_W)) begin : g_bad_default_div
      $error("clk_div_prog: DEFAULT_DIV must be >= 2 and < 2**CNT_W");
   end

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] dact_q, dact_d;
   logic [CNT_W-1:0] dpend_q, dpend_d;
   logic             pend_q, pend_d;

   logic [CNT_W-1:0] div_clamp;
   logic [CNT_W-1:0] d_eff;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] cnt_inc;
   logic             bnd;

   // A load on the boundary edge itself bypasses the pending register.
   assign div_clamp = (div_in < MIN_DIV) ? MIN_DIV : div_in;
   assign d_eff     = div_load ? div_clamp : dpend_q;
   assign half      = (dact_q >> 1) + {{(CNT_W-1){1'b0}}, dact_q[0]};
   assign cnt_inc   = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      dact_d  = dact_q;
      dpend_d = div_load ? div_clamp : dpend_q;
      pend_d  = div_load | pend_q;
      bnd     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (en) begin
               state_d = RUN;
               bnd     = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               clk_d   = 1'b0;
            end else if (sync_clr || (cnt_q == (dact_q - 1'b1))) begin
               bnd = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               clk_d = (cnt_inc < half);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase
      if (bnd) begin
         dact_d = d_eff;
         cnt_d  = '0;
         clk_d  = 1'b1;
         tick_d = 1'b1;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         dact_q  <= RST_DIV;
         dpend_q <= RST_DIV;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         dact_q  <= dact_d;
         dpend_q <= dpend_d;
         pend_q  <= pend_d;
      end
   end

   assign clk_out     = clk_q;
   assign tick        = tick_q;
   assign div_cur     = dact_q;
   assign div_pending = pend_q;

endmodule
